mem_stage_unit: RTL

Parametrised MEM pipeline stage for the MIPS datapath. It sits between the EX/MEM and MEM/WB boundaries and resolves branches (beq/bne). It drives a variable-latency data-memory port with a req/ack handshake and wait-state stall, and supports byte, halfword and word loads and stores with lane steering and sign extension. It owns the MEM/WB register, so all write-back outputs are registered.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/mem_stage_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// memory FSM states and lane-geometry helpers.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_FULL = 2'b11
    } memSize_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } memState_e;

    function automatic int laneCount(input int dataW);
        return dataW / 8;
    endfunction

    function automatic int offsetBits(input int dataW);
        return $clog2(dataW / 8);
    endfunction

    // Number of bytes touched by an access of the given size encoding.
    function automatic int accessBytes(input logic [1:0] size, input int lanes);
        int n;
        n = lanes;
        case (size)
            SZ_BYTE: n = 1;
            SZ_HALF: n = 2;
            SZ_WORD: n = 4;
            default: n = lanes;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: byte enables, store-data
// replication and load extraction with zero/sign extension.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [offsetBits(DATA_W)-1:0] offset,
    input  logic [1:0]                    size,
    input  logic                          loadSigned,
    input  logic [DATA_W-1:0]             storeData,
    input  logic [DATA_W-1:0]             rawLoadData,
    output logic [DATA_W/8-1:0]           byteEnable,
    output logic [DATA_W-1:0]             laneStoreData,
    output logic [DATA_W-1:0]             loadData
);

    localparam int LANES = laneCount(DATA_W);
    localparam int OFF_W = offsetBits(DATA_W);

    logic [OFF_W-1:0]  alignedOff;
    logic [LANES-1:0]  laneMask;
    logic [DATA_W-1:0] shifted;

    // Offset bits below the access size are dropped so every access lands aligned.
    always_comb begin
        alignedOff    = offset & ~OFF_W'(accessBytes(size, LANES) - 1);
        laneMask      = '1;
        laneStoreData = storeData;
        case (memSize_e'(size))
            SZ_BYTE: begin
                laneMask      = LANES'(1);
                laneStoreData = {LANES{storeData[7:0]}};
            end
            SZ_HALF: begin
                laneMask      = LANES'(2'b11);
                laneStoreData = {(LANES/2){storeData[15:0]}};
            end
            SZ_WORD: begin
                laneMask      = LANES'(4'hF);
                laneStoreData = {(LANES/4){storeData[31:0]}};
            end
            SZ_FULL: begin
                laneMask      = '1;
                laneStoreData = storeData;
            end
        endcase
        byteEnable = laneMask << alignedOff;
    end

    always_comb begin
        shifted  = rawLoadData >> {alignedOff, 3'b000};
        loadData = shifted;
        case (memSize_e'(size))
            SZ_BYTE: begin
                if (loadSigned) loadData = DATA_W'($signed(shifted[7:0]));
                else            loadData = DATA_W'(shifted[7:0]);
            end
            SZ_HALF: begin
                if (loadSigned) loadData = DATA_W'($signed(shifted[15:0]));
                else            loadData = DATA_W'(shifted[15:0]);
            end
            SZ_WORD: begin
                if (loadSigned) loadData = DATA_W'($signed(shifted[31:0]));
                else            loadData = DATA_W'(shifted[31:0]);
            end
            SZ_FULL: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// MIPS MEM stage: branch resolution, variable-latency data-memory handshake
// and the MEM/WB register. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                ValidIn,
    input  logic                BranchIn,
    input  logic                BranchNeIn,
    input  logic                MemReadIn,
    input  logic                MemWriteIn,
    input  logic                RegWriteIn,
    input  logic                MemToRegIn,
    input  logic [1:0]          MemSizeIn,
    input  logic                MemSignedIn,
    input  logic [ADDR_W-1:0]   BranchTargetAddressIn,
    input  logic [DATA_W-1:0]   ALUIn,
    input  logic                ZeroIn,
    input  logic [DATA_W-1:0]   MemoryWriteDataIn,
    input  logic [REG_W-1:0]    DestinationRegIn,
    output logic                PCSrcOut,
    output logic [ADDR_W-1:0]   BranchTargetAddressOut,
    output logic                StallOut,
    output logic                DmReq,
    output logic                DmWe,
    output logic [ADDR_W-1:0]   DmAddr,
    output logic [DATA_W-1:0]   DmWData,
    output logic [DATA_W/8-1:0] DmBe,
    input  logic [DATA_W-1:0]   DmRData,
    input  logic                DmAck,
    output logic                ValidOut,
    output logic                RegWriteOut,
    output logic                MemToRegOut,
    output logic [DATA_W-1:0]   ALUOut,
    output logic [DATA_W-1:0]   DataMemOut,
    output logic [REG_W-1:0]    DestinationRegOut,
    output logic                BusErrOut,
    output logic                MisalignOut
);

    localparam int LANES = laneCount(DATA_W);
    localparam int OFF_W = offsetBits(DATA_W);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    memState_e         state, stateNext;
    logic [CNT_W-1:0]  waitCnt, waitCntNext;
    logic [ADDR_W-1:0] heldAddr;
    logic [DATA_W-1:0] heldWData;
    logic [LANES-1:0]  heldBe;
    logic              heldWe;

    logic              memOp, misaligned, reqOp;
    logic              latchReq, complete, abort, stall;
    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] alignedAddr;
    logic [LANES-1:0]  laneBe;
    logic [DATA_W-1:0] laneWData, loadData;

    assign PCSrcOut               = ValidIn & BranchIn & (ZeroIn ^ BranchNeIn);
    assign BranchTargetAddressOut = BranchTargetAddressIn;
    assign memOp                  = ValidIn & (MemReadIn | MemWriteIn);
    assign offset                 = ALUIn[OFF_W-1:0];
    assign alignedAddr            = {ALUIn[ADDR_W-1:OFF_W], OFF_W'(0)};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = memOp && ((int'(offset) & (accessBytes(MemSizeIn, LANES) - 1)) != 0);
`else
    assign misaligned = 1'b0;
`endif
    assign reqOp = memOp & ~misaligned;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) laneAlign (
        .offset        (offset),
        .size          (MemSizeIn),
        .loadSigned    (MemSignedIn),
        .storeData     (MemoryWriteDataIn),
        .rawLoadData   (DmRData),
        .byteEnable    (laneBe),
        .laneStoreData (laneWData),
        .loadData      (loadData)
    );

    // IDLE drives the port straight from the inputs so zero-wait memory never
    // stalls; WAIT replays the latched request until ack or timeout.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        DmReq       = 1'b0;
        DmWe        = 1'b0;
        DmAddr      = alignedAddr;
        DmWData     = laneWData;
        DmBe        = laneBe;
        stall       = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        latchReq    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reqOp) begin
                    DmReq = 1'b1;
                    DmWe  = MemWriteIn;
                    if (DmAck) begin
                        complete = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        latchReq    = 1'b1;
                        waitCntNext = '0;
                        stateNext   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                DmReq   = 1'b1;
                DmWe    = heldWe;
                DmAddr  = heldAddr;
                DmWData = heldWData;
                DmBe    = heldBe;
                if (DmAck) begin
                    complete  = 1'b1;
                    stateNext = ST_IDLE;
                end else if (waitCnt == CNT_W'(TIMEOUT_CYC)) begin
                    DmReq     = 1'b0;
                    DmWe      = 1'b0;
                    abort     = 1'b1;
                    stateNext = ST_IDLE;
                end else begin
                    stall       = 1'b1;
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        if (Rst) begin
            DmReq = 1'b0;
            DmWe  = 1'b0;
        end
    end

    assign StallOut = stall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            waitCnt   <= '0;
            heldAddr  <= '0;
            heldWData <= '0;
            heldBe    <= '0;
            heldWe    <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (latchReq) begin
                heldAddr  <= alignedAddr;
                heldWData <= laneWData;
                heldBe    <= laneBe;
                heldWe    <= MemWriteIn;
            end
        end
    end

    // Stalled and aborted cycles push a bubble into write-back but keep the payload.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ValidOut          <= 1'b0;
            RegWriteOut       <= 1'b0;
            MemToRegOut       <= 1'b0;
            ALUOut            <= '0;
            DataMemOut        <= '0;
            DestinationRegOut <= '0;
            BusErrOut         <= 1'b0;
            MisalignOut       <= 1'b0;
        end else begin
            BusErrOut <= abort;
            if (stall || abort) begin
                ValidOut    <= 1'b0;
                RegWriteOut <= 1'b0;
                MisalignOut <= 1'b0;
            end else begin
                ValidOut          <= ValidIn;
                RegWriteOut       <= RegWriteIn & ~misaligned;
                MemToRegOut       <= MemToRegIn;
                ALUOut            <= ALUIn;
                DestinationRegOut <= DestinationRegIn;
                MisalignOut       <= misaligned;
                if (complete && MemReadIn) begin
                    DataMemOut <= loadData;
                end
            end
        end
    end

endmodule
